bcd_time_decoder: RTL and testbench

//  Iterative BCD-to-binary converter for timer preset entry. It turns six BCD digits (MM:SS.hh) from

---
 rtl/bcd_time_decoder.sv | 162 ++++++++++++++++
 tb/tb_bcd_time_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_decoder.sv
// Iterative BCD (MM:SS.hh) to binary converter for timer preset entry, reverse double-dabble.
// Latency: legal request done in cycle k+8 (busy k+1..k+7); rejected request done in cycle k+1.
// Backpressure: none; start is ignored while busy or done, never queued. Option: BCD_DEC_SATURATE_EN.
module bcd_time_decoder #(
  parameter int MIN_TENS_MAX = 9,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] bcd_10_mins,
  input  logic [3:0] bcd_1_min,
  input  logic [3:0] bcd_10_secs,
  input  logic [3:0] bcd_1_sec,
  input  logic [3:0] bcd_tenths,
  input  logic [3:0] bcd_hundredths,
  output logic [6:0] timer_mins,
  output logic [5:0] timer_secs,
  output logic [6:0] timer_decs,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] MIN_TMAX  = 4'(MIN_TENS_MAX);
  localparam logic [3:0] SEC_TMAX  = 4'(SEC_TENS_MAX);
  localparam logic [2:0] LAST_ITER = 3'd6;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  // Per field: {bcd tens, bcd units, binary accumulator}
  logic [14:0] sh_min, sh_sec, sh_dec;
  logic [14:0] nxt_min, nxt_sec, nxt_dec;
  logic        digits_bad;
  logic [3:0]  cap_10m, cap_1m, cap_10s, cap_1s, cap_t, cap_h;

  // One reverse double-dabble step: shift right, then correct any BCD nibble >= 8.
  function automatic logic [14:0] dabble(input logic [14:0] v);
    logic [14:0] s;
    s = v >> 1;
    if (s[14:11] >= 4'd8) s[14:11] = s[14:11] - 4'd3;
    if (s[10:7]  >= 4'd8) s[10:7]  = s[10:7]  - 4'd3;
    return s;
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Digit legality check on the live inputs; only acted upon at an accepted start.
  always_comb begin
    digits_bad = (bcd_10_mins > DIGIT_MAX) || (bcd_1_min > DIGIT_MAX) ||
                 (bcd_10_secs > DIGIT_MAX) || (bcd_1_sec > DIGIT_MAX) ||
                 (bcd_tenths > DIGIT_MAX)  || (bcd_hundredths > DIGIT_MAX) ||
                 (bcd_10_mins > MIN_TMAX)  || (bcd_10_secs > SEC_TMAX);
  end

  // Values loaded into the shift registers at capture time.
  always_comb begin
`ifdef BCD_DEC_SATURATE_EN
    cap_10m = clamp(clamp(bcd_10_mins, DIGIT_MAX), MIN_TMAX);
    cap_1m  = clamp(bcd_1_min, DIGIT_MAX);
    cap_10s = clamp(clamp(bcd_10_secs, DIGIT_MAX), SEC_TMAX);
    cap_1s  = clamp(bcd_1_sec, DIGIT_MAX);
    cap_t   = clamp(bcd_tenths, DIGIT_MAX);
    cap_h   = clamp(bcd_hundredths, DIGIT_MAX);
`else
    cap_10m = bcd_10_mins;
    cap_1m  = bcd_1_min;
    cap_10s = bcd_10_secs;
    cap_1s  = bcd_1_sec;
    cap_t   = bcd_tenths;
    cap_h   = bcd_hundredths;
`endif
  end

  // Next iteration of all three fields, computed in parallel.
  always_comb begin
    nxt_min = dabble(sh_min);
    nxt_sec = dabble(sh_sec);
    nxt_dec = dabble(sh_dec);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef BCD_DEC_SATURATE_EN
          state_nxt = CONV;
`else
          state_nxt = digits_bad ? DONE : CONV;
`endif
        end
      end
      CONV: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, iterate, and load results only on the final iteration edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 3'd0;
      sh_min     <= 15'd0;
      sh_sec     <= 15'd0;
      sh_dec     <= 15'd0;
      timer_mins <= 7'd0;
      timer_secs <= 6'd0;
      timer_decs <= 7'd0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err    <= digits_bad;
            cnt    <= 3'd0;
            sh_min <= {cap_10m, cap_1m, 7'd0};
            sh_sec <= {cap_10s, cap_1s, 7'd0};
            sh_dec <= {cap_t, cap_h, 7'd0};
          end
        end
        CONV: begin
          cnt    <= cnt + 3'd1;
          sh_min <= nxt_min;
          sh_sec <= nxt_sec;
          sh_dec <= nxt_dec;
          if (cnt == LAST_ITER) begin
            timer_mins <= nxt_min[6:0];
            timer_secs <= nxt_sec[5:0];
            timer_decs <= nxt_dec[6:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_time_decoder.sv
// Directed-vector bench for bcd_time_decoder; expectations are hand-computed constants.
// Cycle n = interval after the n-th rising edge following the start edge k.
// Outputs are sampled on the falling edge, inputs are driven on the falling edge.
module tb_bcd_time_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] b10m, b1m, b10s, b1s, bt, bh;
  logic [6:0] timer_mins;
  logic [5:0] timer_secs;
  logic [6:0] timer_decs;
  logic       busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_time_decoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .bcd_10_mins    (b10m),
    .bcd_1_min      (b1m),
    .bcd_10_secs    (b10s),
    .bcd_1_sec      (b1s),
    .bcd_tenths     (bt),
    .bcd_hundredths (bh),
    .timer_mins     (timer_mins),
    .timer_secs     (timer_secs),
    .timer_decs     (timer_decs),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    {b10m, b1m, b10s, b1s, bt, bh} = 24'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({timer_mins, timer_secs, timer_decs, busy, done, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_state: got mins=%0d secs=%0d decs=%0d busy=%b done=%b err=%b, expected all 0",
               timer_mins, timer_secs, timer_decs, busy, done, err);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Launch one request, optionally pulse start again in the cycles flagged by smask,
  // and scramble the digit inputs once the request has been captured.
  task automatic convert(input string name, input logic [23:0] dig, input logic [15:0] smask,
                         input int exp_done, input int exp_busy,
                         input logic [6:0] em, input logic [5:0] es, input logic [6:0] ed,
                         input logic ee);
    int first_done = 0;
    int done_cnt   = 0;
    int busy_cnt   = 0;
    @(negedge clk);
    {b10m, b1m, b10s, b1s, bt, bh} = dig;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
      if (busy === 1'b1) busy_cnt++;
      start = smask[n];
      if (n == 1) {b10m, b1m, b10s, b1s, bt, bh} = 24'hFFFFFF;
    end
    start = 1'b0;
    n_checks++;
    if (first_done != exp_done) begin
      n_fail++;
      $display("FAIL %s done_cycle: got k+%0d expected k+%0d", name, first_done, exp_done);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    n_checks++;
    if (busy_cnt != exp_busy) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
    end
    n_checks++;
    if (timer_mins !== em) begin
      n_fail++;
      $display("FAIL %s mins: got %0d expected %0d", name, timer_mins, em);
    end
    n_checks++;
    if (timer_secs !== es) begin
      n_fail++;
      $display("FAIL %s secs: got %0d expected %0d", name, timer_secs, es);
    end
    n_checks++;
    if (timer_decs !== ed) begin
      n_fail++;
      $display("FAIL %s decs: got %0d expected %0d", name, timer_decs, ed);
    end
    n_checks++;
    if (err !== ee) begin
      n_fail++;
      $display("FAIL %s err: got %b expected %b", name, err, ee);
    end
  endtask

  task automatic test_max_values();
    convert("max_59_59_99", 24'h595999, 16'h0, 8, 7, 7'd59, 6'd59, 7'd99, 1'b0);
  endtask

  task automatic test_illegal();
`ifdef BCD_DEC_SATURATE_EN
    convert("sec_tens_6", 24'h126000, 16'h0, 8, 7, 7'd12, 6'd50, 7'd0, 1'b1);
    convert("nibble_A",   24'h0A7000, 16'h0, 8, 7, 7'd9,  6'd50, 7'd0, 1'b1);
`else
    convert("sec_tens_6", 24'h126000, 16'h0, 1, 0, 7'd59, 6'd59, 7'd99, 1'b1);
    convert("nibble_A",   24'h0A7000, 16'h0, 1, 0, 7'd59, 6'd59, 7'd99, 1'b1);
`endif
  endtask

  task automatic test_zero_then_99();
    convert("all_zero",  24'h000000, 16'h0, 8, 7, 7'd0,  6'd0,  7'd0, 1'b0);
    convert("mins_99",   24'h995901, 16'h0, 8, 7, 7'd99, 6'd59, 7'd1, 1'b0);
  endtask

  task automatic test_back_to_back();
    convert("start_ignored", 24'h013050, 16'h0024, 8, 7, 7'd1, 6'd30, 7'd50, 1'b0);
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    @(negedge clk);
    {b10m, b1m, b10s, b1s, bt, bh} = 24'h595999;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) done_seen++;
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({timer_mins, timer_secs, timer_decs, busy, done, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got mins=%0d secs=%0d decs=%0d busy=%b done=%b err=%b, expected all 0",
               timer_mins, timer_secs, timer_decs, busy, done, err);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %0d done pulses expected 0", done_seen);
    end
    convert("after_reset", 24'h234567, 16'h0, 8, 7, 7'd23, 6'd45, 7'd67, 1'b0);
  endtask

  initial begin
    test_reset();
    test_max_values();
    test_illegal();
    test_zero_then_99();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
